// File: rtl/uart_rx_buffer.sv
// Receive buffer behind the UART RX deserializer: one byte captured per frame-good
// pulse, held in a first-word-fall-through FIFO, with overflow and error-frame status.
module uart_rx_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ERR_CNT_W  = 8,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  data_valid,
    input  logic                  par_err,
    input  logic                  stp_err,
    input  logic                  out_ready,
    input  logic                  clr_stat,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]      fifo_count,
    output logic                  full,
    output logic                  overflow,
    output logic [ERR_CNT_W-1:0]  err_cnt
);

    localparam logic [CNT_W-1:0]     COUNT_FULL = CNT_W'(DEPTH);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX    = {ERR_CNT_W{1'b1}};

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 dv_q, err_q;

    logic push_req, pop, do_push, drop, err_edge, is_full, is_empty;

    assign is_full   = (count_q == COUNT_FULL);
    assign is_empty  = (count_q == '0);

    // Edge detectors reset high so a level already asserted at reset release is ignored.
    assign push_req  = data_valid & ~dv_q;
    assign err_edge  = (par_err | stp_err) & ~err_q;

    assign pop       = ~is_empty & out_ready;
    assign do_push   = push_req & (~is_full | pop);
    assign drop      = push_req & is_full & ~pop;

    assign out_valid  = ~is_empty;
    assign out_data   = is_empty ? '0 : mem_q[rd_ptr_q];
    assign fifo_count = count_q;
    assign full       = is_full;
    assign overflow   = overflow_q;
    assign err_cnt    = err_cnt_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        err_cnt_d  = err_cnt_q;

        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({do_push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A status event in the same cycle as a clear takes precedence over the clear.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_stat) begin
            overflow_d = 1'b0;
        end

        if (clr_stat) begin
            err_cnt_d = err_edge ? ERR_CNT_W'(1) : '0;
        end else if (err_edge && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            err_cnt_q  <= '0;
            dv_q       <= 1'b1;
            err_q      <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            err_cnt_q  <= err_cnt_d;
            dv_q       <= data_valid;
            err_q      <= par_err | stp_err;
        end
    end

    // Storage carries no reset; stale contents are never visible because out_data is gated by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= P_DATA;
        end
    end

endmodule
